// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// controller state encoding and the default memory depth.
package lsu_pkg;

  localparam int DEFAULT_WORD_ADDR_W = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of the pipeline request/response handshake and the word-addressed
// data memory port. The load/store unit sits on the slave side; the pipeline
// plus memory environment sits on the master side.
interface lsu_mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/lsu_mem_port_lane.sv
// Little-endian lane logic used in the capture step: extracts and extends a
// byte/half from a memory word for loads, and merges the low byte/half of
// store data into the addressed lane of a memory word for sub-word stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_value,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_mask;

  // Shift the addressed lane down for loads and build the merged store word
  always_comb begin
    shamt      = (size == SIZE_HALF) ? {offset[1], 4'b0000} : {offset, 3'b000};
    lane_b     = 8'(rdata >> shamt);
    lane_h     = 16'(rdata >> shamt);
    load_value = rdata;
    lane_mask  = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: begin
        load_value = {{24{is_signed & lane_b[7]}}, lane_b};
        lane_mask  = 32'h0000_00FF;
      end
      SIZE_HALF: begin
        load_value = {{16{is_signed & lane_h[15]}}, lane_h};
        lane_mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase
    store_word = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator. Latches one request, checks it, and walks
// the memory port through read, capture and write steps as needed. Sub-word
// stores are read-modify-write; loads are lane-extracted and extended.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_W = DEFAULT_WORD_ADDR_W
) (
  input logic           clock,
  input logic           reset,
  lsu_mem_port_if.slave bus
);

  lsu_state_t state;
  lsu_state_t state_next;

  logic [WORD_ADDR_W-1:0] word_q;
  logic [1:0]             offset_q;
  logic [1:0]             size_q;
  logic                   we_q;
  logic                   signed_q;
  logic                   err_q;
  logic [31:0]            wdata_q;
  logic [31:0]            result_q;

  logic        accept;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  assign accept = bus.req_valid && (state == ST_IDLE);

  // Flag reserved sizes, misalignment and addresses beyond the memory depth
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == SIZE_RSVD)
      req_err = 1'b1;
    if ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
      req_err = 1'b1;
    if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
    if ((bus.req_addr >> (WORD_ADDR_W + 2)) != 32'd0)
      req_err = 1'b1;
  end

  lsu_lane u_lane (
    .offset     (offset_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .rdata      (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_value (lane_load),
    .store_word (lane_store)
  );

  // Controller state register; reset abandons any in-flight request
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Sequence: errors go straight to respond, word stores skip the read
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)
            state_next = ST_RESP;
          else if (!bus.req_we)
            state_next = ST_RD;
          else if (bus.req_size == SIZE_WORD)
            state_next = ST_WR;
          else
            state_next = ST_RD;
        end
      end
      ST_RD:   state_next = ST_CAP;
      ST_CAP:  state_next = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch request fields on accept, then capture load result or merged word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      offset_q <= 2'b00;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
    end else if (accept) begin
      word_q   <= bus.req_addr[WORD_ADDR_W+1:2];
      offset_q <= bus.req_addr[1:0];
      size_q   <= bus.req_size;
      we_q     <= bus.req_we;
      signed_q <= bus.req_signed;
      err_q    <= req_err;
      wdata_q  <= bus.req_wdata;
      result_q <= 32'd0;
    end else if (state == ST_CAP) begin
      if (we_q)
        wdata_q <= lane_store;
      else
        result_q <= lane_load;
    end
  end

  // Drive handshake and memory strobes purely from state and latched data
  always_comb begin
    bus.req_ready  = (state == ST_IDLE);
    bus.mem_re     = (state == ST_RD);
    bus.mem_we     = (state == ST_WR);
    bus.resp_valid = (state == ST_RESP);
    bus.resp_err   = (state == ST_RESP) && err_q;
    bus.resp_rdata = (state == ST_RESP) ? result_q : 32'd0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    if (state != ST_IDLE) begin
      bus.mem_addr  = {{(32 - WORD_ADDR_W){1'b0}}, word_q};
      bus.mem_wdata = wdata_q;
    end
  end

endmodule
